// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrapping register range through a read port and streams each value over valid/ready
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = $clog2(NUM_REGS),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] idx, last_r;
  logic hs;
  assign hs = dump_valid && dump_ready;
  assign rf_addr = idx;
  assign busy = (state == FETCH) || (state == SEND);
  assign done = state == DONE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = (state == IDLE) ? (start ? FETCH : IDLE) :
          (state == DONE) ? IDLE :
          abort ? IDLE :
          (state == FETCH) ? SEND :
          hs ? (dump_last ? DONE : FETCH) : SEND;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      last_r <= '0;
      dump_valid <= 1'b0;
      dump_data <= '0;
      dump_idx <= '0;
      dump_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        idx <= first_idx;
        last_r <= last_idx;
      end
      if (state == FETCH && !abort) begin
        dump_data <= (idx == '0) ? '0 : rf_data;
        dump_idx <= idx;
        dump_last <= idx == last_r;
        dump_valid <= 1'b1;
      end
      if (state == SEND && (abort || hs)) dump_valid <= 1'b0;
      if (state == SEND && !abort && hs && !dump_last) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed and randomized dumps checked against a range/array reference model
module tb_regfile_dump;
  logic clk = 0, rst = 1, start = 0, abort = 0, dump_ready = 0;
  logic [4:0] first_idx = 0, last_idx = 0, rf_addr, dump_idx;
  logic [31:0] rf_data, dump_data;
  logic dump_valid, dump_last, busy, done;
  logic we = 0;
  logic [4:0] wa = 0;
  logic [31:0] wd = 0;
  logic [31:0] rf_q [32];
  logic [31:0] m [32];
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (we) rf_q[wa] <= wd;
  assign rf_data = rf_q[rf_addr];
  regfile_dump dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .dump_last(dump_last), .busy(busy), .done(done)
  );
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic preload(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      we = 1;
      wa = 5'(i);
      wd = rnd ? $urandom : (i == 9 ? 32'h20 : (i == 0 ? 32'hdeadbeef : 32'h100 + i));
      m[i] = wd;
      step();
    end
    we = 0;
  endtask
  task automatic dump(input int first, input int last, input int stall_mode, input int abort_beat,
                      input bit wr3, input bit start_mid);
    int n, t0, stalls, ns, g;
    int q_idx[$];
    logic [31:0] q_dat[$];
    n = ((last - first + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      q_idx.push_back((first + k) % 32);
      q_dat.push_back(((first + k) % 32) == 0 ? 32'h0 : m[(first + k) % 32]);
    end
    start = 1;
    first_idx = 5'(first);
    last_idx = 5'(last);
    step();
    start = 0;
    t0 = cyc;
    check("busy_fetch", busy, 1);
    check("valid_fetch", dump_valid, 0);
    if (wr3) begin
      we = 1;
      wa = 3;
      wd = ~m[3];
    end
    step();
    if (wr3) m[3] = wd;
    we = 0;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      g = 0;
      while (!dump_valid && g < 8) begin
        step();
        g++;
      end
      check("valid", dump_valid, 1);
      check("idx", dump_idx, q_idx[b]);
      check("data", dump_data, q_dat[b]);
      check("last", dump_last, b == n - 1);
      check("rf_addr", rf_addr, q_idx[b]);
      ns = stall_mode == 0 ? 0 : stall_mode == 1 ? 2 : $urandom_range(0, 2);
      for (int s = 0; s < ns; s++) begin
        dump_ready = 0;
        if (start_mid && b == 1 && s == 0) begin
          start = 1;
          first_idx = 20;
          last_idx = 21;
        end
        step();
        start = 0;
        stalls++;
        check("stall_valid", dump_valid, 1);
        check("stall_idx", dump_idx, q_idx[b]);
        check("stall_data", dump_data, q_dat[b]);
        check("stall_done", done, 0);
      end
      dump_ready = 1;
      if (b == abort_beat) begin
        abort = 1;
        step();
        abort = 0;
        check("abort_valid", dump_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int r = 0; r < 4; r++) begin
          step();
          check("post_abort_valid", dump_valid, 0);
          check("post_abort_done", done, 0);
        end
        return;
      end
      step();
      check("hs_valid", dump_valid, 0);
      if (b < n - 1) check("early_done", done, 0);
    end
    check("done", done, 1);
    check("done_cycle", cyc - t0, 2 * n + stalls);
    check("done_busy", busy, 0);
    step();
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_rf_addr", rf_addr, q_idx[n - 1]);
  endtask
  initial begin
    step();
    step();
    check("rst_valid", dump_valid, 0);
    check("rst_data", dump_data, 0);
    check("rst_idx", dump_idx, 0);
    check("rst_last", dump_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rf_addr", rf_addr, 0);
    rst = 0;
    preload(0);
    dump(0, 31, 0, -1, 0, 0);
    dump(4, 6, 1, -1, 0, 0);
    dump(30, 1, 0, -1, 0, 0);
    dump(7, 7, 0, -1, 0, 0);
    dump(0, 31, 0, 5, 0, 0);
    dump(2, 4, 0, -1, 0, 0);
    dump(10, 12, 1, -1, 0, 1);
    dump(3, 3, 0, -1, 1, 0);
    dump(3, 3, 0, -1, 0, 0);
    start = 1;
    first_idx = 0;
    last_idx = 31;
    step();
    start = 0;
    repeat (7) step();
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_valid", dump_valid, 0);
    check("mid_rst_data", dump_data, 0);
    check("mid_rst_idx", dump_idx, 0);
    check("mid_rst_last", dump_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rf_addr", rf_addr, 0);
    step();
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    preload(1);
    for (int i = 0; i < 4; i++)
      dump($urandom_range(0, 31), $urandom_range(0, 31), 2, -1, 0, 0);
    dump(9, 8, 2, -1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
